// File: rtl/ram1_ctrl.sv
// Sequences single-word CPU read/write requests onto the RAM1 pin wrapper.
// Latency: accept to resp_valid is STROBE_CYCLES+2 cycles; back-to-back accepts are STROBE_CYCLES+3 apart.
// Backpressure: req_ready is high only in IDLE; a request held valid while busy waits for the next IDLE.
module ram1_ctrl #(
   parameter int unsigned STROBE_CYCLES = 2,
   parameter logic [1:0]  BANK          = 2'b00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        resp_valid,
   output logic [15:0] resp_rdata,
   output logic [17:0] ram_addr,
   output logic [15:0] ram_wdata,
   output logic        ram_read,
   output logic        ram_strobe,
   input  logic [15:0] ram_rdata
);

   // A zero width is promoted to one cycle; the 4-bit counter caps the width at 15.
   localparam int unsigned STROBE_EFF =
      (STROBE_CYCLES == 0) ? 1 : ((STROBE_CYCLES > 15) ? 15 : STROBE_CYCLES);
   localparam logic [3:0] CNT_LOAD = 4'(STROBE_EFF - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] counter;
   logic       accept;
   logic       strobe_done;

   // Handshake and phase decodes; all come straight from registered state.
   assign req_ready   = (state == IDLE);
   assign resp_valid  = (state == HOLD);
   assign accept      = (state == IDLE) && req_valid;
   assign strobe_done = (state == STROBE) && (counter == 4'd0);

   // State register; reset returns to IDLE immediately, abandoning any transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state sequencing: setup, strobe for the programmed width, then one hold cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_valid) state_nxt = SETUP;
         SETUP:   state_nxt = STROBE;
         STROBE:  if (counter == 4'd0) state_nxt = HOLD;
         HOLD:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobe width counter: loaded during SETUP, counts down to zero across STROBE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         counter <= 4'd0;
      end else if (state == SETUP) begin
         counter <= CNT_LOAD;
      end else if ((state == STROBE) && (counter != 4'd0)) begin
         counter <= counter - 4'd1;
      end
   end

   // Address and write data are captured only on accept and held through HOLD.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_addr  <= 18'd0;
         ram_wdata <= 16'd0;
      end else if (accept) begin
         ram_addr  <= {BANK, req_addr};
         ram_wdata <= req_wdata;
      end
   end

   // Bus direction flips only on IDLE->SETUP and HOLD->IDLE, both strobe-low, so no contention.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_read <= 1'b0;
      end else if (accept) begin
         ram_read <= req_write;
      end else if (state == HOLD) begin
         ram_read <= 1'b0;
      end
   end

   // Registered strobe: high exactly while the FSM sits in STROBE, so OE/WE cannot glitch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_strobe <= 1'b0;
      end else begin
         ram_strobe <= (state_nxt == STROBE);
      end
   end

   // Read data is sampled on the last strobe edge while OE is still asserted; writes leave it alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_rdata <= 16'd0;
      end else if (strobe_done && !ram_read) begin
         resp_rdata <= ram_rdata;
      end
   end

endmodule

// File: tb/tb_ram1_ctrl.sv
// Directed bench for ram1_ctrl: three instances cover strobe widths 2, 1 and 15.
// Expected read data is queued at accept and compared when resp_valid appears.
// Outputs are sampled 1 time unit after each rising edge.
module tb_ram1_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req_valid;
   logic        req_write;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic [15:0] ram_rdata;
   logic [2:0]  req_ready;
   logic [2:0]  resp_valid;
   logic [2:0]  ram_read;
   logic [2:0]  ram_strobe;
   logic [15:0] resp_rdata [3];
   logic [15:0] ram_wdata  [3];
   logic [17:0] ram_addr   [3];

   int          sc [3] = '{2, 1, 15};
   logic [1:0]  bk [3] = '{2'b00, 2'b10, 2'b10};

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] exp_q [$];
   logic [15:0] last_rd [3];
   logic        cur_wr;
   logic [15:0] cur_addr;
   logic [15:0] cur_wd;

   always #5 clk = ~clk;

   ram1_ctrl #(.STROBE_CYCLES(2), .BANK(2'b00)) dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .ram_addr(ram_addr[0]),
      .ram_wdata(ram_wdata[0]), .ram_read(ram_read[0]), .ram_strobe(ram_strobe[0]),
      .ram_rdata(ram_rdata));

   ram1_ctrl #(.STROBE_CYCLES(1), .BANK(2'b10)) dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .ram_addr(ram_addr[1]),
      .ram_wdata(ram_wdata[1]), .ram_read(ram_read[1]), .ram_strobe(ram_strobe[1]),
      .ram_rdata(ram_rdata));

   ram1_ctrl #(.STROBE_CYCLES(15), .BANK(2'b10)) dut2 (
      .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]), .ram_addr(ram_addr[2]),
      .ram_wdata(ram_wdata[2]), .ram_read(ram_read[2]), .ram_strobe(ram_strobe[2]),
      .ram_rdata(ram_rdata));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a request to instance k, take the accept edge, then scramble req_* to prove it is ignored.
   task automatic start_txn(input int k, input logic wr, input logic [15:0] a,
                            input logic [15:0] wd, input logic [15:0] rd);
      req_write = wr;
      req_addr  = a;
      req_wdata = wd;
      ram_rdata = rd;
      cur_wr    = wr;
      cur_addr  = a;
      cur_wd    = wd;
      check("ready_before_accept", 32'(req_ready[k]), 32'd1);
      req_valid[k] = 1'b1;
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
      exp_q.push_back(wr ? last_rd[k] : rd);
      if (!wr) last_rd[k] = rd;
      req_addr  = ~a;
      req_wdata = ~wd;
      req_write = ~wr;
   endtask

   // Follow instance k from the post-accept sample to the next ready, checking phasing on the way.
   task automatic finish_txn(input int k, output int lat, output int gap, output int sw);
      logic [15:0] exp_rd;
      lat = -1;
      gap = -1;
      sw  = 0;
      for (int i = 0; i < 40; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
         end
         check("addr_held", 32'(ram_addr[k]), 32'({bk[k], cur_addr}));
         check("wdata_held", 32'(ram_wdata[k]), 32'(cur_wd));
         check("mode_held", 32'(ram_read[k]), 32'(cur_wr));
         if (i == 0) check("strobe_low_setup", 32'(ram_strobe[k]), 32'd0);
         if (ram_strobe[k]) sw++;
         if (resp_valid[k]) begin
            lat = i + 1;
            check("strobe_low_hold", 32'(ram_strobe[k]), 32'd0);
            check("sb_pending", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) begin
               exp_rd = exp_q.pop_front();
               check("resp_rdata", 32'(resp_rdata[k]), 32'(exp_rd));
            end
            break;
         end
      end
      if (lat > 0) begin
         for (int j = 0; j < 40; j++) begin
            @(posedge clk); #1;
            check("resp_single_pulse", 32'(resp_valid[k]), 32'd0);
            if (req_ready[k]) begin
               gap = lat + 1 + j;
               check("idle_mode_read", 32'(ram_read[k]), 32'd0);
               check("idle_strobe_low", 32'(ram_strobe[k]), 32'd0);
               break;
            end
         end
      end
   endtask

   initial begin
      int lat, gap, sw, pulses;
      rst       = 1'b1;
      req_valid = 3'b000;
      req_write = 1'b0;
      req_addr  = 16'h0;
      req_wdata = 16'h0;
      ram_rdata = 16'h0;
      for (int k = 0; k < 3; k++) last_rd[k] = 16'h0;
      #3;
      check("rst_ready", 32'(req_ready), 32'h7);
      check("rst_resp_valid", 32'(resp_valid), 32'h0);
      check("rst_strobe", 32'(ram_strobe), 32'h0);
      check("rst_read", 32'(ram_read), 32'h0);
      check("rst_addr", 32'(ram_addr[0]), 32'h0);
      check("rst_wdata", 32'(ram_wdata[0]), 32'h0);
      check("rst_rdata", 32'(resp_rdata[0]), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Plain read, width 2.
      start_txn(0, 1'b0, 16'h1234, 16'h0000, 16'hA5C3);
      check("read_addr_map", 32'(ram_addr[0]), 32'h01234);
      finish_txn(0, lat, gap, sw);
      check("read_latency", 32'(lat), 32'd4);
      check("read_strobe_width", 32'(sw), 32'd2);
      check("read_gap", 32'(gap), 32'd5);
      check("read_rdata_held", 32'(resp_rdata[0]), 32'hA5C3);

      // Write must not disturb resp_rdata even with junk on the bus.
      start_txn(0, 1'b1, 16'h0010, 16'h00FF, 16'hDEAD);
      finish_txn(0, lat, gap, sw);
      check("write_latency", 32'(lat), 32'd4);
      check("write_strobe_width", 32'(sw), 32'd2);
      check("write_rdata_kept", 32'(resp_rdata[0]), 32'hA5C3);

      // Write then read with req_valid held high throughout.
      start_txn(0, 1'b1, 16'h0020, 16'h1111, 16'hBEEF);
      req_valid[0] = 1'b1;
      finish_txn(0, lat, gap, sw);
      check("b2b_write_latency", 32'(lat), 32'd4);
      check("b2b_accept_spacing", 32'(gap), 32'd5);
      start_txn(0, 1'b0, 16'h0030, 16'h2222, 16'h5A5A);
      finish_txn(0, lat, gap, sw);
      check("b2b_read_latency", 32'(lat), 32'd4);
      check("b2b_read_rdata", 32'(resp_rdata[0]), 32'h5A5A);

      // Width 1, bank 2, top address.
      start_txn(1, 1'b0, 16'hFFFF, 16'h0000, 16'h1357);
      check("w1_addr_no_carry", 32'(ram_addr[1]), 32'h2FFFF);
      finish_txn(1, lat, gap, sw);
      check("w1_latency", 32'(lat), 32'd3);
      check("w1_strobe_width", 32'(sw), 32'd1);
      check("w1_gap", 32'(gap), 32'd4);
      start_txn(1, 1'b1, 16'hFFFF, 16'hC0DE, 16'h9999);
      finish_txn(1, lat, gap, sw);
      check("w1_write_latency", 32'(lat), 32'd3);
      check("w1_write_rdata_kept", 32'(resp_rdata[1]), 32'h1357);

      // Width 15, bank 2, top address.
      start_txn(2, 1'b0, 16'hFFFF, 16'h0000, 16'h2468);
      check("w15_addr_no_carry", 32'(ram_addr[2]), 32'h2FFFF);
      finish_txn(2, lat, gap, sw);
      check("w15_latency", 32'(lat), 32'd17);
      check("w15_strobe_width", 32'(sw), 32'd15);
      check("w15_gap", 32'(gap), 32'd18);

      // Reset in the middle of a write strobe.
      req_write = 1'b1;
      req_addr  = 16'h0040;
      req_wdata = 16'h7777;
      req_valid[0] = 1'b1;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      @(posedge clk); #1;
      check("pre_rst_strobe", 32'(ram_strobe[0]), 32'd1);
      check("pre_rst_mode", 32'(ram_read[0]), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_strobe", 32'(ram_strobe[0]), 32'd0);
      check("mid_rst_mode", 32'(ram_read[0]), 32'd0);
      check("mid_rst_ready", 32'(req_ready[0]), 32'd1);
      check("mid_rst_resp", 32'(resp_valid[0]), 32'd0);
      check("mid_rst_addr", 32'(ram_addr[0]), 32'd0);
      check("mid_rst_rdata", 32'(resp_rdata[0]), 32'd0);
      for (int k = 0; k < 3; k++) last_rd[k] = 16'h0;
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (resp_valid[0]) pulses++;
      end
      check("no_resp_after_rst", 32'(pulses), 32'd0);

      // Recovery read after reset.
      start_txn(0, 1'b0, 16'h0ACE, 16'h0000, 16'h3C3C);
      finish_txn(0, lat, gap, sw);
      check("post_rst_latency", 32'(lat), 32'd4);
      check("post_rst_rdata", 32'(resp_rdata[0]), 32'h3C3C);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
